// File: rtl/vregister_sequencer_if.sv
// -----------------------------------------------------------------------------
// vregister_sequencer_if
//   Command handshake bundle between a command source (master) and the
//   register sequencer (slave).
//
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave  -> master sequencer can accept (only while idle)
//   cmd_op     master -> slave  0=LOAD 1=UP 2=DOWN 3=SEEK
//   cmd_data   master -> slave  LOAD value / SEEK target
//   cmd_count  master -> slave  step count for UP/DOWN
// -----------------------------------------------------------------------------
interface vregister_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [WIDTH-1:0]     cmd_data;
    logic [CNT_WIDTH-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/vregister_sequencer.sv
// -----------------------------------------------------------------------------
// vregister_sequencer
//   Command-side driver for a counting register with a 2-bit ctrl port
//   (NONE/LOAD/INCR/DECR). High-level commands (load, step up N, step down N,
//   seek to target) arrive over a valid/ready handshake and are expanded into
//   a cycle-by-cycle ctrl/data stream. A shadow copy tracks the register
//   output every cycle, and done pulses for one cycle when a command finishes.
//
//   clk         clock, all state updates on the rising edge
//   sync_reset  synchronous active-high reset
//   cmd         command handshake (slave side of vregister_sequencer_if)
//   ctrl        register ctrl: 0=NONE 1=LOAD 2=INCR 3=DECR (registered)
//   reg_data    register data_in, meaningful while ctrl=LOAD (registered)
//   shadow      mirror of the register output
//   busy        a command is in progress
//   done        one-cycle completion pulse
// -----------------------------------------------------------------------------
module vregister_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    vregister_sequencer_if.slave   cmd,
    output logic [1:0]             ctrl,
    output logic [WIDTH-1:0]       reg_data,
    output logic [WIDTH-1:0]       shadow,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_SEEK = 2'd3;

    localparam logic [1:0] CTRL_NONE = 2'd0;
    localparam logic [1:0] CTRL_LOAD = 2'd1;
    localparam logic [1:0] CTRL_INCR = 2'd2;
    localparam logic [1:0] CTRL_DECR = 2'd3;

    localparam logic [WIDTH-1:0]     ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] ZERO_C  = '0;

    state_t               state_q,    state_d;
    logic [1:0]           ctrl_q,     ctrl_d;
    logic [WIDTH-1:0]     reg_data_q, reg_data_d;
    logic [WIDTH-1:0]     shadow_q,   shadow_d;
    logic                 done_q,     done_d;
    logic [CNT_WIDTH-1:0] remain_q,   remain_d;
    logic [WIDTH-1:0]     target_q,   target_d;
    logic                 dir_up_q,   dir_up_d;
    logic                 seek_q,     seek_d;

    // Value the shadow (and the register) will hold after the current step.
    logic [WIDTH-1:0]     step_val;
    logic                 last_step;

    assign step_val  = dir_up_q ? (shadow_q + ONE_W) : (shadow_q - ONE_W);

    // A SEEK ends on the edge where the shadow lands on the target; UP/DOWN
    // end when the final counted step is being issued.
    assign last_step = seek_q ? (step_val == target_q) : (remain_q == ONE_C);

    // Next-state and next-output logic. ctrl is computed one cycle ahead so
    // that the registered ctrl lines up with the state it belongs to: the
    // accepting edge already loads the first LOAD/INCR/DECR code.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = CTRL_NONE;
        reg_data_d = reg_data_q;
        shadow_d   = shadow_q;
        done_d     = 1'b0;
        remain_d   = remain_q;
        target_d   = target_q;
        dir_up_d   = dir_up_q;
        seek_d     = seek_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            state_d    = ST_LOAD;
                            ctrl_d     = CTRL_LOAD;
                            reg_data_d = cmd.cmd_data;
                        end
                        OP_UP, OP_DOWN: begin
                            seek_d   = 1'b0;
                            dir_up_d = (cmd.cmd_op == OP_UP);
                            remain_d = cmd.cmd_count;
                            if (cmd.cmd_count == ZERO_C) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_STEP;
                                ctrl_d  = (cmd.cmd_op == OP_UP) ? CTRL_INCR : CTRL_DECR;
                            end
                        end
                        default: begin
                            // SEEK: direction from an unsigned compare, so the
                            // walk never crosses the wrap point.
                            seek_d   = 1'b1;
                            target_d = cmd.cmd_data;
                            dir_up_d = (cmd.cmd_data > shadow_q);
                            if (cmd.cmd_data == shadow_q) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_STEP;
                                ctrl_d  = (cmd.cmd_data > shadow_q) ? CTRL_INCR : CTRL_DECR;
                            end
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                shadow_d = reg_data_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_STEP: begin
                shadow_d = step_val;
                remain_d = remain_q - ONE_C;
                if (last_step) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ctrl_d  = dir_up_q ? CTRL_INCR : CTRL_DECR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any command in flight without
    // a done pulse; the register is expected to be reset on the same edge so
    // a zero shadow stays truthful.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= CTRL_NONE;
            reg_data_q <= '0;
            shadow_q   <= '0;
            done_q     <= 1'b0;
            remain_q   <= '0;
            target_q   <= '0;
            dir_up_q   <= 1'b0;
            seek_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            reg_data_q <= reg_data_d;
            shadow_q   <= shadow_d;
            done_q     <= done_d;
            remain_q   <= remain_d;
            target_q   <= target_d;
            dir_up_q   <= dir_up_d;
            seek_q     <= seek_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign ctrl          = ctrl_q;
    assign reg_data      = reg_data_q;
    assign shadow        = shadow_q;
    assign done          = done_q;

endmodule
